task_graph_sequencer: RTL and testbench

Controller that stores one application task graph as an NUM_V×NUM_V adjacency matrix and streams it, element by element, into `task_mapper`. It drives the mapper's `task_array`, `root_task`, `row`, `col` and `app_end` inputs with the mapper's two-cycle-per-element cadence. It repeats the application a programmed number of times and stalls on mapper back-pressure. It sits between the configuration/host side and `task_mapper`, and replaces bench-driven streaming in the integrated design.

---
 rtl/task_graph_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_task_graph_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_graph_sequencer.sv
// task_graph_sequencer: holds one NUM_V x NUM_V task-graph adjacency matrix and
// streams it row-major into task_mapper at two cycles per entry. It repeats the
// application num_apps times and stalls in HOLD while mt_ready is low.
// Optional build macro: SKIP_ZERO_EN. When it is defined, zero entries take a single
// PRESENT cycle with task_valid low, and mt_ready is not checked for them.
module task_graph_sequencer #(
    parameter int unsigned NUM_V  = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned APP_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_row,
    input  logic [IDX_W-1:0]  cfg_col,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic [APP_W-1:0]  num_apps,
    input  logic              mt_ready,
    output logic [DATA_W-1:0] task_array,
    output logic              task_valid,
    output logic              root_task,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col,
    output logic              app_end,
    output logic              busy,
    output logic              done,
    output logic [APP_W-1:0]  app_cnt
);

    localparam int unsigned NUM_E  = NUM_V * NUM_V;
    localparam int unsigned ADDR_W = (NUM_E > 1) ? $clog2(NUM_E) : 1;
    localparam int unsigned NZ_W   = $clog2(NUM_E + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_V - 1);

    typedef enum logic [2:0] {IDLE, PRESENT, HOLD, GAP1, APPEND, GAP2} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   mem [NUM_E];
    logic [APP_W-1:0]    apps_lat, apps_n;
    logic [NZ_W-1:0]     nz_cnt, nz_n, nz_base;
    logic [DATA_W-1:0]   data_n, pres_data;
    logic [IDX_W-1:0]    row_n, col_n, pres_row, pres_col;
    logic [ADDR_W-1:0]   pres_idx, wr_idx;
    logic [APP_W-1:0]    app_cnt_n;
    logic                valid_n, root_n, app_end_n, done_n;
    logic                present, advance, wr_en;

    // Row-major linear address of a matrix entry.
    function automatic logic [ADDR_W-1:0] lin(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(NUM_V) + ADDR_W'(c);
    endfunction

    // Matrix writes are accepted only in IDLE and only inside the matrix bounds.
    always_comb begin
        wr_en  = (state == IDLE) && cfg_we &&
                 (cfg_row < IDX_W'(NUM_V)) && (cfg_col < IDX_W'(NUM_V));
        wr_idx = lin(cfg_row, cfg_col);
    end

    // Matrix storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_E; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= cfg_data;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col;
        data_n    = task_array;
        valid_n   = 1'b0;
        root_n    = 1'b0;
        app_end_n = 1'b0;
        done_n    = 1'b0;
        app_cnt_n = app_cnt;
        nz_n      = nz_cnt;
        apps_n    = apps_lat;
        present   = 1'b0;
        advance   = 1'b0;
        pres_row  = '0;
        pres_col  = '0;
        nz_base   = nz_cnt;
        pres_idx  = '0;
        pres_data = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (num_apps == '0) begin
                        done_n = 1'b1;
                    end else begin
                        apps_n    = num_apps;
                        app_cnt_n = '0;
                        nz_base   = '0;
                        present   = 1'b1;
                    end
                end
            end
            PRESENT: begin
`ifdef SKIP_ZERO_EN
                if (task_array == '0) begin
                    advance = 1'b1;
                end else begin
                    state_n = HOLD;
                    valid_n = 1'b1;
                end
`else
                state_n = HOLD;
                valid_n = 1'b1;
`endif
            end
            HOLD: begin
                if (mt_ready) begin
                    advance = 1'b1;
                end else begin
                    valid_n = 1'b1;
                end
            end
            GAP1: begin
                state_n   = APPEND;
                app_end_n = 1'b1;
                app_cnt_n = app_cnt + APP_W'(1);
            end
            APPEND: begin
                state_n = GAP2;
            end
            GAP2: begin
                if (app_cnt == apps_lat) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    nz_base = '0;
                    present = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Step to the next entry, or close the application after the last one.
        if (advance) begin
            if ((row == LAST_IDX) && (col == LAST_IDX)) begin
                state_n = GAP1;
            end else begin
                present = 1'b1;
                if (col == LAST_IDX) begin
                    pres_row = row + IDX_W'(1);
                    pres_col = '0;
                end else begin
                    pres_row = row;
                    pres_col = col + IDX_W'(1);
                end
            end
        end

        // Load the entry being presented; a same-cycle IDLE write is bypassed in.
        if (present) begin
            pres_idx  = lin(pres_row, pres_col);
            pres_data = (wr_en && (wr_idx == pres_idx)) ? cfg_data : mem[pres_idx];
            state_n   = PRESENT;
            row_n     = pres_row;
            col_n     = pres_col;
            data_n    = pres_data;
`ifdef SKIP_ZERO_EN
            valid_n   = (pres_data != '0);
`else
            valid_n   = 1'b1;
`endif
            root_n    = (pres_data != '0) && (nz_base == '0);
            nz_n      = nz_base + NZ_W'(pres_data != '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            task_array <= '0;
            task_valid <= 1'b0;
            root_task  <= 1'b0;
            row        <= '0;
            col        <= '0;
            app_end    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            app_cnt    <= '0;
            nz_cnt     <= '0;
            apps_lat   <= '0;
        end else begin
            state      <= state_n;
            task_array <= data_n;
            task_valid <= valid_n;
            root_task  <= root_n;
            row        <= row_n;
            col        <= col_n;
            app_end    <= app_end_n;
            busy       <= (state_n != IDLE);
            done       <= done_n;
            app_cnt    <= app_cnt_n;
            nz_cnt     <= nz_n;
            apps_lat   <= apps_n;
        end
    end

endmodule

// File: tb/tb_task_graph_sequencer.sv
// Directed self-checking bench for task_graph_sequencer (NUM_V = 3).
module tb_task_graph_sequencer;

    localparam int NV = 3;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [IW-1:0] cfg_row, cfg_col;
    logic [DW-1:0] cfg_data;
    logic          start;
    logic [AW-1:0] num_apps;
    logic          mt_ready;
    logic [DW-1:0] task_array;
    logic          task_valid, root_task, app_end, busy, done;
    logic [IW-1:0] row, col;
    logic [AW-1:0] app_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_m [9] = '{5, 0, 6, 0, 6, 0, 7, 0, 0};

    logic [DW-1:0] tr_data  [100];
    logic          tr_valid [100];
    logic          tr_root  [100];
    logic          tr_end   [100];
    logic          tr_done  [100];
    logic          tr_busy  [100];
    logic [IW-1:0] tr_row   [100];
    logic [IW-1:0] tr_col   [100];
    logic [AW-1:0] tr_cnt   [100];

    task_graph_sequencer #(.NUM_V(NV), .DATA_W(DW), .IDX_W(IW), .APP_W(AW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_data(cfg_data), .start(start), .num_apps(num_apps), .mt_ready(mt_ready),
        .task_array(task_array), .task_valid(task_valid), .root_task(root_task),
        .row(row), .col(col), .app_end(app_end), .busy(busy), .done(done), .app_cnt(app_cnt)
    );

    always #5 clk = ~clk;

    task automatic write_cell(input int r, input int c, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_row = IW'(r); cfg_col = IW'(c); cfg_data = DW'(d);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic load_matrix();
        for (int k = 0; k < 9; k++) write_cell(k / NV, k % NV, exp_m[k]);
    endtask

    // Start pulse in cycle 0 (sampled at edge 0), optionally with a matrix write.
    task automatic do_start(input int n, input bit we, input int r, input int c, input int d);
        @(negedge clk);
        start = 1'b1; num_apps = AW'(n);
        cfg_we = we; cfg_row = IW'(r); cfg_col = IW'(c); cfg_data = DW'(d);
        @(posedge clk);
        #1 start = 1'b0; cfg_we = 1'b0;
    endtask

    // Records cycles 1..ncyc; drives mt_ready low for edges stall_at..stall_at+stall_len-1,
    // and at cycle inj_at issues a start plus a write that must both be ignored.
    task automatic capture(input int ncyc, input int stall_at, input int stall_len, input int inj_at);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            tr_data[c] = task_array; tr_valid[c] = task_valid; tr_root[c] = root_task;
            tr_end[c] = app_end; tr_done[c] = done; tr_busy[c] = busy;
            tr_row[c] = row; tr_col[c] = col; tr_cnt[c] = app_cnt;
            mt_ready = (c >= stall_at && c < stall_at + stall_len) ? 1'b0 : 1'b1;
            if (c == inj_at) begin
                start = 1'b1; num_apps = AW'(2);
                cfg_we = 1'b1; cfg_row = IW'(2); cfg_col = IW'(2); cfg_data = DW'(99);
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
        end
        mt_ready = 1'b1; start = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({task_array, task_valid, root_task, row, col, app_end, busy, done, app_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got data=%0d valid=%b root=%b row=%0d col=%0d end=%b busy=%b done=%b cnt=%0d, expected all 0",
                     task_array, task_valid, root_task, row, col, app_end, busy, done, app_cnt);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_zero_apps();
        do_start(0, 1'b0, 0, 0, 0);
        capture(3, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({tr_done[c], tr_valid[c], tr_busy[c]} !== {c == 1, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL zero_apps: cycle %0d got done=%b valid=%b busy=%b, expected done=%b valid=0 busy=0",
                         c, tr_done[c], tr_valid[c], tr_busy[c], c == 1);
            end
        end
    endtask

`ifdef SKIP_ZERO_EN
    task automatic test_skip_zero();
        int sv [13] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
        int sd [13] = '{5, 5, 0, 6, 6, 0, 6, 6, 0, 7, 7, 0, 0};
        int sr [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        int sc [13] = '{0, 0, 1, 2, 2, 0, 1, 1, 2, 0, 0, 1, 2};
        load_matrix();
        do_start(1, 1'b0, 0, 0, 0);
        capture(20, 0, 0, 0);
        for (int c = 1; c <= 13; c++) begin
            n_cmp++;
            if ({tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c]} !==
                {sv[c-1] != 0, DW'(sd[c-1]), IW'(sr[c-1]), IW'(sc[c-1]), c == 1}) begin
                n_bad++;
                $display("FAIL skip_stream: cycle %0d got v=%b d=%0d r=%0d c=%0d root=%b, expected v=%0d d=%0d r=%0d c=%0d root=%b",
                         c, tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c],
                         sv[c-1], sd[c-1], sr[c-1], sc[c-1], c == 1);
            end
        end
        for (int c = 1; c <= 20; c++) begin
            n_cmp++;
            if ({tr_end[c], tr_done[c], tr_valid[c] && tr_data[c] == '0} !== {c == 15, c == 17, 1'b0}) begin
                n_bad++;
                $display("FAIL skip_ctrl: cycle %0d got end=%b done=%b valid=%b data=%0d, expected end=%b done=%b no zero-valid",
                         c, tr_end[c], tr_done[c], tr_valid[c], tr_data[c], c == 15, c == 17);
            end
        end
    endtask
`else
    task automatic test_single_app();
        load_matrix();
        do_start(1, 1'b0, 0, 0, 0);
        capture(24, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            for (int p = 0; p < 2; p++) begin
                int c = 2 * k + 1 + p;
                n_cmp++;
                if ({tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c]} !==
                    {1'b1, DW'(exp_m[k]), IW'(k / NV), IW'(k % NV), k == 0 && p == 0}) begin
                    n_bad++;
                    $display("FAIL single_entry: cycle %0d got v=%b d=%0d r=%0d c=%0d root=%b, expected v=1 d=%0d r=%0d c=%0d root=%b",
                             c, tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c],
                             exp_m[k], k / NV, k % NV, k == 0 && p == 0);
                end
            end
        end
        for (int c = 19; c <= 24; c++) begin
            n_cmp++;
            if ({tr_valid[c], tr_end[c], tr_done[c], tr_busy[c]} !== {1'b0, c == 20, c == 22, c <= 21}) begin
                n_bad++;
                $display("FAIL single_ctrl: cycle %0d got valid=%b end=%b done=%b busy=%b, expected valid=0 end=%b done=%b busy=%b",
                         c, tr_valid[c], tr_end[c], tr_done[c], tr_busy[c], c == 20, c == 22, c <= 21);
            end
        end
        n_cmp++;
        if (tr_cnt[22] !== AW'(1)) begin
            n_bad++;
            $display("FAIL single_app_cnt: got %0d, expected 1", tr_cnt[22]);
        end
    endtask

    task automatic test_repeat();
        do_start(3, 1'b0, 0, 0, 0);
        capture(66, 0, 0, 0);
        for (int a = 0; a < 3; a++) begin
            for (int k = 0; k < 9; k++) begin
                for (int p = 0; p < 2; p++) begin
                    int c = 21 * a + 2 * k + 1 + p;
                    n_cmp++;
                    if ({tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c]} !==
                        {1'b1, DW'(exp_m[k]), IW'(k / NV), IW'(k % NV), k == 0 && p == 0}) begin
                        n_bad++;
                        $display("FAIL repeat_entry: app %0d cycle %0d got v=%b d=%0d r=%0d c=%0d root=%b, expected d=%0d r=%0d c=%0d root=%b",
                                 a, c, tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c],
                                 exp_m[k], k / NV, k % NV, k == 0 && p == 0);
                    end
                end
            end
        end
        for (int c = 1; c <= 66; c++) begin
            n_cmp++;
            if ({tr_end[c], tr_done[c], tr_busy[c]} !== {c == 20 || c == 41 || c == 62, c == 64, c <= 63}) begin
                n_bad++;
                $display("FAIL repeat_ctrl: cycle %0d got end=%b done=%b busy=%b, expected end=%b done=%b busy=%b",
                         c, tr_end[c], tr_done[c], tr_busy[c], c == 20 || c == 41 || c == 62, c == 64, c <= 63);
            end
        end
        n_cmp++;
        if ({tr_cnt[21], tr_cnt[42], tr_cnt[64]} !== {AW'(1), AW'(2), AW'(3)}) begin
            n_bad++;
            $display("FAIL repeat_app_cnt: got %0d/%0d/%0d, expected 1/2/3", tr_cnt[21], tr_cnt[42], tr_cnt[64]);
        end
    endtask

    task automatic test_back_pressure();
        do_start(1, 1'b0, 0, 0, 0);
        capture(27, 10, 4, 0);
        for (int k = 0; k < 9; k++) begin
            for (int p = 0; p < 2; p++) begin
                int c = 2 * k + 1 + p + ((k > 4) ? 4 : 0);
                if (k == 4) continue;
                n_cmp++;
                if ({tr_valid[c], tr_data[c], tr_row[c], tr_col[c]} !==
                    {1'b1, DW'(exp_m[k]), IW'(k / NV), IW'(k % NV)}) begin
                    n_bad++;
                    $display("FAIL bp_entry: cycle %0d got v=%b d=%0d r=%0d c=%0d, expected d=%0d r=%0d c=%0d",
                             c, tr_valid[c], tr_data[c], tr_row[c], tr_col[c], exp_m[k], k / NV, k % NV);
                end
            end
        end
        for (int c = 9; c <= 14; c++) begin
            n_cmp++;
            if ({tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c]} !==
                {1'b1, DW'(6), IW'(1), IW'(1), 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold: cycle %0d got v=%b d=%0d r=%0d c=%0d root=%b, expected v=1 d=6 r=1 c=1 root=0",
                         c, tr_valid[c], tr_data[c], tr_row[c], tr_col[c], tr_root[c]);
            end
        end
        for (int c = 20; c <= 27; c++) begin
            n_cmp++;
            if ({tr_end[c], tr_done[c]} !== {c == 24, c == 26}) begin
                n_bad++;
                $display("FAIL bp_ctrl: cycle %0d got end=%b done=%b, expected end=%b done=%b",
                         c, tr_end[c], tr_done[c], c == 24, c == 26);
            end
        end
    endtask

    task automatic test_protocol();
        // start and a write to (2,2) issued mid-run must leave the stream untouched
        do_start(1, 1'b0, 0, 0, 0);
        capture(24, 0, 0, 5);
        for (int k = 0; k < 9; k++) begin
            int c = 2 * k + 2;
            n_cmp++;
            if ({tr_valid[c], tr_data[c], tr_row[c], tr_col[c]} !== {1'b1, DW'(exp_m[k]), IW'(k / NV), IW'(k % NV)}) begin
                n_bad++;
                $display("FAIL busy_ignore_entry: cycle %0d got v=%b d=%0d r=%0d c=%0d, expected d=%0d r=%0d c=%0d",
                         c, tr_valid[c], tr_data[c], tr_row[c], tr_col[c], exp_m[k], k / NV, k % NV);
            end
        end
        n_cmp++;
        if ({tr_done[22], tr_cnt[22], tr_busy[23], tr_done[24]} !== {1'b1, AW'(1), 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL busy_ignore_done: got done22=%b cnt=%0d busy23=%b done24=%b, expected 1/1/0/0",
                     tr_done[22], tr_cnt[22], tr_busy[23], tr_done[24]);
        end
        // out-of-range writes are dropped
        write_cell(3, 0, 77);
        write_cell(0, 3, 77);
        do_start(1, 1'b0, 0, 0, 0);
        capture(23, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            int c = 2 * k + 1;
            n_cmp++;
            if ({tr_valid[c], tr_data[c]} !== {1'b1, DW'(exp_m[k])}) begin
                n_bad++;
                $display("FAIL oob_write: cycle %0d got v=%b d=%0d, expected v=1 d=%0d",
                         c, tr_valid[c], tr_data[c], exp_m[k]);
            end
        end
        // write landing together with start is seen by the scan
        do_start(1, 1'b1, 0, 0, 9);
        capture(23, 0, 0, 0);
        n_cmp++;
        if ({tr_valid[1], tr_data[1], tr_root[1], tr_data[2], tr_data[5], tr_root[5]} !==
            {1'b1, DW'(9), 1'b1, DW'(9), DW'(6), 1'b0}) begin
            n_bad++;
            $display("FAIL start_with_write: got v1=%b d1=%0d root1=%b d2=%0d d5=%0d root5=%b, expected 1/9/1/9/6/0",
                     tr_valid[1], tr_data[1], tr_root[1], tr_data[2], tr_data[5], tr_root[5]);
        end
        write_cell(0, 0, 5);
    endtask
`endif

    task automatic test_midrun_reset();
        int n_valid, n_nz, n_root, n_done;
        do_start(2, 1'b0, 0, 0, 0);
        repeat (9) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({task_array, task_valid, root_task, row, col, app_end, busy, done, app_cnt} !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: got data=%0d valid=%b root=%b row=%0d col=%0d end=%b busy=%b done=%b cnt=%0d, expected all 0",
                     task_array, task_valid, root_task, row, col, app_end, busy, done, app_cnt);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, task_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b done=%b valid=%b, expected 0/0/0", busy, done, task_valid);
        end
        do_start(1, 1'b0, 0, 0, 0);
        capture(30, 0, 0, 0);
        n_valid = 0; n_nz = 0; n_root = 0; n_done = 0;
        for (int c = 1; c <= 30; c++) begin
            if (tr_valid[c] === 1'b1) n_valid++;
            if (tr_valid[c] === 1'b1 && tr_data[c] !== '0) n_nz++;
            if (tr_root[c] !== 1'b0) n_root++;
            if (tr_done[c] === 1'b1) n_done++;
        end
        n_cmp++;
`ifdef SKIP_ZERO_EN
        if (n_valid != 0 || n_nz != 0 || n_root != 0 || n_done != 1) begin
`else
        if (n_valid != 18 || n_nz != 0 || n_root != 0 || n_done != 1) begin
`endif
            n_bad++;
            $display("FAIL reset_readback: got valid=%0d nonzero=%0d root=%0d done=%0d, expected cleared matrix with one done",
                     n_valid, n_nz, n_root, n_done);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; start = 1'b0; mt_ready = 1'b1;
        cfg_row = '0; cfg_col = '0; cfg_data = '0; num_apps = '0;
        test_reset();
        test_zero_apps();
`ifdef SKIP_ZERO_EN
        test_skip_zero();
`else
        test_single_app();
        test_repeat();
        test_back_pressure();
        test_protocol();
`endif
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
